// File: rtl/bcd_score_board.sv
// Debounced multi-channel BCD score counter with a time-multiplexed seven-segment driver.
// Per-button debouncers and per-channel counters are lane sub-modules instantiated by the top.

module bcd_score_board_db #(
    parameter int DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_rise
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_rise;

    // Sync flops are reset too, so a button held through reset re-qualifies from scratch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync   <= '0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_rise   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            r_rise <= 1'b0;
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                r_stable <= r_sync[1];
                r_rise   <= r_sync[1];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rise = r_rise;
endmodule

module bcd_score_board_chan #(
    parameter int DIGITS = 2,
    parameter int WRAP   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clr,
    input  logic                i_inc,
    input  logic                i_dec,
    output logic [DIGITS*4-1:0] o_score,
    output logic                o_hit,
    output logic                o_wrap
);
    logic [DIGITS*4-1:0] r_score;
    logic [DIGITS*4-1:0] w_inc_val;
    logic [DIGITS*4-1:0] w_dec_val;
    logic                r_hit;
    logic                r_wrap;
    logic                w_all9;
    logic                w_all0;

    // Ripple carry/borrow; the carry out of the top digit doubles as the all-9s / all-0s flag.
    always_comb begin
        w_inc_val = r_score;
        w_dec_val = r_score;
        w_all9    = 1'b1;
        w_all0    = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_all9) begin
                if (r_score[d*4 +: 4] == 4'd9) begin
                    w_inc_val[d*4 +: 4] = 4'd0;
                end else begin
                    w_inc_val[d*4 +: 4] = r_score[d*4 +: 4] + 4'd1;
                    w_all9 = 1'b0;
                end
            end
            if (w_all0) begin
                if (r_score[d*4 +: 4] == 4'd0) begin
                    w_dec_val[d*4 +: 4] = 4'd9;
                end else begin
                    w_dec_val[d*4 +: 4] = r_score[d*4 +: 4] - 4'd1;
                    w_all0 = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_score <= '0;
            r_hit   <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_hit  <= 1'b0;
            r_wrap <= 1'b0;
            if (i_clr) begin
                r_score <= '0;
            end else if (i_inc && !i_dec) begin
                r_hit  <= 1'b1;
                r_wrap <= w_all9;
                if (!(w_all9 && (WRAP == 0))) r_score <= w_inc_val;
            end else if (i_dec && !i_inc && !w_all0) begin
                r_score <= w_dec_val;
            end
        end
    end

    assign o_score = r_score;
    assign o_hit   = r_hit;
    assign o_wrap  = r_wrap;
endmodule

module bcd_score_board #(
    parameter int N_CH      = 2,
    parameter int DIGITS    = 2,
    parameter int DB_CYCLES = 250000,
    parameter int PRESCALE  = 131072,
    parameter int WRAP      = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CH-1:0]            btn_inc,
    input  logic [N_CH-1:0]            btn_dec,
    input  logic                       clr,
    output logic [N_CH*DIGITS*4-1:0]   score,
    output logic [N_CH-1:0]            hit,
    output logic [N_CH-1:0]            wrap,
    output logic [N_CH*DIGITS-1:0]     disp_select,
    output logic [7:0]                 seven_value
);
    localparam int NSLOT = N_CH * DIGITS;
    localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    logic [N_CH-1:0] w_inc_str;
    logic [N_CH-1:0] w_dec_str;
    logic [PW-1:0]   r_pre;
    logic [IW-1:0]   r_idx;
    logic [3:0]      w_digit;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        bcd_score_board_db #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
            .clk(clk), .reset(reset), .i_raw(btn_inc[c]), .o_rise(w_inc_str[c])
        );
        bcd_score_board_db #(.DB_CYCLES(DB_CYCLES)) u_db_dec (
            .clk(clk), .reset(reset), .i_raw(btn_dec[c]), .o_rise(w_dec_str[c])
        );
        bcd_score_board_chan #(.DIGITS(DIGITS), .WRAP(WRAP)) u_chan (
            .clk(clk), .reset(reset), .i_clr(clr),
            .i_inc(w_inc_str[c]), .i_dec(w_dec_str[c]),
            .o_score(score[c*DIGITS*4 +: DIGITS*4]),
            .o_hit(hit[c]), .o_wrap(wrap[c])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PW'(PRESCALE - 1)) begin
            r_pre <= '0;
            r_idx <= (r_idx == IW'(NSLOT - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign disp_select = ~(NSLOT'(1) << r_idx);

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < NSLOT; i++) begin
            if (r_idx == IW'(i)) w_digit = score[i*4 +: 4];
        end
    end

    // Segment order {a,b,c,d,e,f,g,dp}, active low, dp always off.
    always_comb begin
        case (w_digit)
            4'd0:    seven_value = ~8'hFC;
            4'd1:    seven_value = ~8'h60;
            4'd2:    seven_value = ~8'hDA;
            4'd3:    seven_value = ~8'hF2;
            4'd4:    seven_value = ~8'h66;
            4'd5:    seven_value = ~8'hB6;
            4'd6:    seven_value = ~8'hBE;
            4'd7:    seven_value = ~8'hE0;
            4'd8:    seven_value = ~8'hFE;
            4'd9:    seven_value = ~8'hF6;
            default: seven_value = 8'hFF;
        endcase
    end
endmodule

// File: tb/tb_bcd_score_board.sv
// Bench for bcd_score_board: a WRAP=1 and a WRAP=0 instance share stimulus and are
// compared every cycle against an integer-valued reference model, plus directed checks.

module tb_bcd_score_board;
    localparam int N_CH  = 2;
    localparam int DIGITS = 2;
    localparam int DB    = 4;
    localparam int PRE   = 4;
    localparam int NSLOT = N_CH * DIGITS;
    localparam int NIN   = 2 * N_CH;
    localparam int MAXV  = 99;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  btn_inc = '0;
    logic [1:0]  btn_dec = '0;
    logic [15:0] score_w, score_s;
    logic [1:0]  hit_w, hit_s, wrap_w, wrap_s;
    logic [3:0]  sel_w, sel_s;
    logic [7:0]  seg_w, seg_s;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] seg_tab [10] = '{~8'hFC, ~8'h60, ~8'hDA, ~8'hF2, ~8'h66,
                                 ~8'hB6, ~8'hBE, ~8'hE0, ~8'hFE, ~8'hF6};
    logic [3:0] sel_seq [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] seg_seq [4]  = '{~8'hDA, ~8'h60, ~8'h66, ~8'hF2};
    localparam logic [7:0] SEG_ZERO = ~8'hFC;

    always #5 clk = ~clk;

    bcd_score_board #(.N_CH(N_CH), .DIGITS(DIGITS), .DB_CYCLES(DB), .PRESCALE(PRE), .WRAP(1)) u_dut (
        .clk(clk), .reset(reset), .btn_inc(btn_inc), .btn_dec(btn_dec), .clr(clr),
        .score(score_w), .hit(hit_w), .wrap(wrap_w), .disp_select(sel_w), .seven_value(seg_w)
    );
    bcd_score_board #(.N_CH(N_CH), .DIGITS(DIGITS), .DB_CYCLES(DB), .PRESCALE(PRE), .WRAP(0)) u_sat (
        .clk(clk), .reset(reset), .btn_inc(btn_inc), .btn_dec(btn_dec), .clr(clr),
        .score(score_s), .hit(hit_s), .wrap(wrap_s), .disp_select(sel_s), .seven_value(seg_s)
    );

    // Reference model: scores as plain integers, debouncers as "delayed input must
    // differ from accepted level for DB consecutive cycles". Index md: 0 = wrap, 1 = saturate.
    int m_d1 [NIN], m_d2 [NIN], m_stab [NIN], m_run [NIN], m_rise [NIN];
    int m_sc [2][N_CH];
    bit m_hit [2][N_CH], m_wrap [2][N_CH];
    int m_cyc = 0;

    logic [1:0] seen_hit_w, seen_hit_s, seen_wrap_w, seen_wrap_s;

    task automatic model_tick();
        int inc_s, dec_s, raw;
        if (!reset) begin
            for (int i = 0; i < NIN; i++) begin
                m_d1[i] = 0; m_d2[i] = 0; m_stab[i] = 0; m_run[i] = 0; m_rise[i] = 0;
            end
            for (int md = 0; md < 2; md++)
                for (int c = 0; c < N_CH; c++) begin
                    m_sc[md][c] = 0; m_hit[md][c] = 0; m_wrap[md][c] = 0;
                end
            m_cyc = 0;
        end else begin
            for (int md = 0; md < 2; md++)
                for (int c = 0; c < N_CH; c++) begin
                    inc_s = m_rise[c];
                    dec_s = m_rise[N_CH + c];
                    m_hit[md][c]  = 0;
                    m_wrap[md][c] = 0;
                    if (clr) m_sc[md][c] = 0;
                    else if (inc_s != 0 && dec_s != 0) ;
                    else if (inc_s != 0) begin
                        m_hit[md][c] = 1;
                        if (m_sc[md][c] == MAXV) begin
                            m_wrap[md][c] = 1;
                            m_sc[md][c] = (md == 0) ? 0 : MAXV;
                        end else m_sc[md][c] = m_sc[md][c] + 1;
                    end else if (dec_s != 0 && m_sc[md][c] > 0) m_sc[md][c] = m_sc[md][c] - 1;
                end
            for (int i = 0; i < NIN; i++) begin
                raw = (i < N_CH) ? int'(btn_inc[i]) : int'(btn_dec[i - N_CH]);
                m_rise[i] = 0;
                if (m_d2[i] != m_stab[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DB) begin
                        m_stab[i] = m_d2[i];
                        m_rise[i] = m_d2[i];
                        m_run[i]  = 0;
                    end
                end else m_run[i] = 0;
                m_d2[i] = m_d1[i];
                m_d1[i] = raw;
            end
            m_cyc = m_cyc + 1;
        end
    endtask

    function automatic int p10(input int d);
        int r = 1;
        for (int k = 0; k < d; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] exp_bus(input int md);
        logic [15:0] b = '0;
        for (int c = 0; c < N_CH; c++)
            for (int d = 0; d < DIGITS; d++)
                b[(c*DIGITS+d)*4 +: 4] = 4'((m_sc[md][c] / p10(d)) % 10);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int idx, dig;
        logic [3:0] e_sel;
        logic [7:0] e_seg;
        logic [1:0] e_hit, e_wrap;
        idx   = (m_cyc / PRE) % NSLOT;
        e_sel = 4'(~(1 << idx));
        for (int md = 0; md < 2; md++) begin
            for (int c = 0; c < N_CH; c++) begin
                e_hit[c]  = m_hit[md][c];
                e_wrap[c] = m_wrap[md][c];
            end
            dig   = (m_sc[md][idx / DIGITS] / p10(idx % DIGITS)) % 10;
            e_seg = seg_tab[dig];
            if (md == 0) begin
                chk("score_w", score_w, exp_bus(0));
                chk("hit_w", hit_w, e_hit);
                chk("wrap_w", wrap_w, e_wrap);
                chk("sel_w", sel_w, e_sel);
                chk("seg_w", seg_w, e_seg);
            end else begin
                chk("score_s", score_s, exp_bus(1));
                chk("hit_s", hit_s, e_hit);
                chk("wrap_s", wrap_s, e_wrap);
                chk("sel_s", sel_s, e_sel);
                chk("seg_s", seg_s, e_seg);
            end
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_tick();
            @(negedge clk);
            check_all();
            seen_hit_w  |= hit_w;
            seen_hit_s  |= hit_s;
            seen_wrap_w |= wrap_w;
            seen_wrap_s |= wrap_s;
        end
    endtask

    task automatic clear_seen();
        seen_hit_w = '0; seen_hit_s = '0; seen_wrap_w = '0; seen_wrap_s = '0;
    endtask

    task automatic press(input logic [1:0] inc_m, input logic [1:0] dec_m);
        btn_inc = inc_m;
        btn_dec = dec_m;
        step(8);
        btn_inc = '0;
        btn_dec = '0;
        step(8);
    endtask

    // Edges from the current point until hit_w[0] is first seen; -1 if never within the bound.
    task automatic lat_wait(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (hit_w[0] && lat < 0) lat = k;
        end
    endtask

    initial begin
        int lat;
        bit found;
        clear_seen();

        // Reset state
        reset = 1'b0;
        step(2);
        chk("rst_sel", sel_w, 4'b1110);
        chk("rst_seg", seg_w, SEG_ZERO);
        chk("rst_score", score_w, 16'h0000);
        reset = 1'b1;
        step(8);

        // Debounce latency and glitch rejection
        btn_inc = 2'b01;
        lat_wait(lat);
        chk("inc_latency", lat, DB + 3);
        chk("first_inc", score_w[7:0], 8'h01);
        btn_inc = '0;
        step(10);
        clear_seen();
        btn_inc = 2'b10;
        step(3);
        btn_inc = '0;
        step(12);
        chk("glitch_hit", seen_hit_w[1], 1'b0);
        chk("glitch_score", score_w[15:8], 8'h00);

        // Carry, borrow, floor at zero
        for (int i = 0; i < 8; i++) press(2'b01, 2'b00);
        chk("preload_09", score_w[7:0], 8'h09);
        press(2'b01, 2'b00);
        chk("carry_10", score_w[7:0], 8'h10);
        press(2'b00, 2'b01);
        chk("borrow_09", score_w[7:0], 8'h09);
        for (int i = 0; i < 9; i++) press(2'b00, 2'b01);
        clear_seen();
        press(2'b00, 2'b01);
        chk("floor_00", score_w[7:0], 8'h00);
        chk("floor_wrap", seen_wrap_w[0], 1'b0);

        // Wrap vs saturate at 99
        for (int i = 0; i < 99; i++) press(2'b01, 2'b00);
        chk("at_99", score_w[7:0], 8'h99);
        clear_seen();
        press(2'b01, 2'b00);
        chk("wrap_score", score_w[7:0], 8'h00);
        chk("wrap_hit", seen_hit_w[0], 1'b1);
        chk("wrap_pulse", seen_wrap_w[0], 1'b1);
        chk("sat_score", score_s[7:0], 8'h99);
        chk("sat_hit", seen_hit_s[0], 1'b1);
        chk("sat_pulse", seen_wrap_s[0], 1'b1);

        // Simultaneous events
        clr = 1'b1; step(1); clr = 1'b0; step(1);
        chk("clr_sat", score_s, 16'h0000);
        press(2'b10, 2'b00);
        clear_seen();
        press(2'b10, 2'b10);
        chk("incdec_score", score_w[15:8], 8'h01);
        chk("incdec_hit", seen_hit_w[1], 1'b0);
        press(2'b11, 2'b00);
        chk("dual_inc", score_w, 16'h0201);
        btn_inc = 2'b11;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1);
            if (m_rise[0] != 0) found = 1'b1;
        end
        chk("strobe_found", found, 1'b1);
        clear_seen();
        clr = 1'b1; step(1); clr = 1'b0;
        btn_inc = '0;
        step(8);
        chk("clr_inc_w", score_w, 16'h0000);
        chk("clr_inc_s", score_s, 16'h0000);
        chk("clr_inc_hit", seen_hit_w, 2'b00);

        // Display scan with ch0=12, ch1=34
        for (int i = 0; i < 12; i++) press(2'b11, 2'b00);
        for (int i = 0; i < 22; i++) press(2'b10, 2'b00);
        chk("scan_preload", score_w, 16'h3412);
        found = 1'b0;
        for (int k = 0; k < 16 && !found; k++) begin
            if (sel_w == 4'b1110) found = 1'b1;
            else step(1);
        end
        chk("scan_sync", found, 1'b1);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++) begin
                chk("scan_sel", sel_w, sel_seq[k]);
                chk("scan_seg", seg_w, seg_seq[k]);
                step(4);
            end

        // Reset in the middle of a held press
        btn_inc = 2'b01;
        step(3);
        reset = 1'b0;
        step(2);
        chk("midrst_score", score_w, 16'h0000);
        reset = 1'b1;
        lat_wait(lat);
        chk("midrst_latency", lat, DB + 3);
        btn_inc = '0;
        step(8);
        chk("midrst_count", score_w, 16'h0001);

        // Randomized button activity, including short glitches and stray clears
        for (int k = 0; k < 2000; k++) begin
            for (int b = 0; b < N_CH; b++) begin
                if ($urandom_range(0, 4) == 0) btn_inc[b] = ~btn_inc[b];
                if ($urandom_range(0, 7) == 0) btn_dec[b] = ~btn_dec[b];
            end
            clr = ($urandom_range(0, 199) == 0);
            step(1);
        end
        btn_inc = '0;
        btn_dec = '0;
        clr = 1'b0;
        step(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
